// File: rtl/fetch_pkg.sv
// Shared types for the instruction fetch unit.
//   fetch_state_e : fetch FSM states
//   entry_t       : one fetched instruction as queued toward decode
//   ENTRY_W       : packed width of entry_t
//   make_entry()  : builds an entry, forcing instr to zero on an address error
package fetch_pkg;

  localparam int unsigned ENTRY_W = 65;

  typedef enum logic [1:0] {
    StIdle,
    StReq,
    StWait,
    StDrop
  } fetch_state_e;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } entry_t;

  function automatic entry_t make_entry(input logic [31:0] pc, input logic [31:0] instr,
                                        input logic adel);
    entry_t e;
    e.pc    = pc;
    e.instr = adel ? 32'h0 : instr;
    e.adel  = adel;
    return e;
  endfunction

endpackage

// File: rtl/fetch_fifo.sv
// Synchronous in-order FIFO holding fetched entries.
// Ports:
//   clk_i, rst_i  : clock, synchronous active-high reset
//   clear_i       : drop all entries at the next edge (wins over push/pop)
//   push_i/data_i : write an entry (ignored when full)
//   pop_i         : retire the head (ignored when empty)
//   head_o        : head entry, read straight from storage registers
//   count_o       : number of valid entries
module fetch_fifo
  import fetch_pkg::*;
#(
  parameter int unsigned Depth  = 4,
  parameter type         EntryT = logic [ENTRY_W-1:0]
) (
  input  logic                     clk_i,
  input  logic                     rst_i,
  input  logic                     clear_i,
  input  logic                     push_i,
  input  EntryT                    data_i,
  input  logic                     pop_i,
  output EntryT                    head_o,
  output logic [$clog2(Depth):0]   count_o
);

  localparam int unsigned PtrW = $clog2(Depth);
  localparam int unsigned CntW = PtrW + 1;

  EntryT            mem_q [Depth];
  logic [PtrW-1:0]  wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0]  count_q;
  logic             do_push, do_pop;

  always_comb begin
    do_push = push_i && (count_q != CntW'(Depth));
    do_pop  = pop_i && (count_q != '0);
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || clear_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + PtrW'(1);
      if (do_pop)  rd_ptr_q <= rd_ptr_q + PtrW'(1);
      unique case ({do_push, do_pop})
        2'b10:   count_q <= count_q + CntW'(1);
        2'b01:   count_q <= count_q - CntW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible while counted.
  always_ff @(posedge clk_i) begin
    if (do_push) mem_q[wr_ptr_q] <= data_i;
  end

  assign head_o  = mem_q[rd_ptr_q];
  assign count_o = count_q;

endmodule

// File: rtl/instr_fetch_unit.sv
// Instruction fetch unit: takes PCs, fetches words from instruction memory over a
// req/gnt/rvalid interface (one transaction in flight), and queues {pc, instr, adel}
// toward decode. Misaligned PCs bypass memory and are queued as address errors.
// Ports:
//   clk, rst                     : clock, synchronous active-high reset
//   pc_valid/pc_ready/pc_in      : PC input handshake
//   flush                        : discard queue and any in-flight fetch
//   imem_req/imem_addr/imem_gnt  : memory request channel
//   imem_rvalid/imem_rdata       : memory response channel
//   if_valid/if_ready            : decode handshake on queue head
//   if_pc/if_instr/if_adel       : head entry fields (zero when if_valid is low)
module instr_fetch_unit
  import fetch_pkg::*;
#(
  parameter int unsigned DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        pc_valid,
  input  logic [31:0] pc_in,
  output logic        pc_ready,
  input  logic        flush,
  output logic        imem_req,
  output logic [31:0] imem_addr,
  input  logic        imem_gnt,
  input  logic        imem_rvalid,
  input  logic [31:0] imem_rdata,
  output logic        if_valid,
  input  logic        if_ready,
  output logic [31:0] if_pc,
  output logic [31:0] if_instr,
  output logic        if_adel
);

  localparam int unsigned CntW = $clog2(DEPTH) + 1;

  fetch_state_e    state_q, state_d;
  logic [31:0]     addr_q, addr_d;
  logic            push;
  entry_t          push_entry;
  entry_t          head;
  logic [CntW-1:0] count;
  logic            accept;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= StIdle;
      addr_q  <= '0;
    end else begin
      state_q <= state_d;
      addr_q  <= addr_d;
    end
  end

  always_comb begin
    state_d    = state_q;
    addr_d     = addr_q;
    push       = 1'b0;
    push_entry = '0;
    imem_req   = 1'b0;
    // A single outstanding transaction plus acceptance only in idle means a
    // free slot at acceptance is still free when the response arrives.
    pc_ready   = (state_q == StIdle) && (count < CntW'(DEPTH)) && !flush && !rst;
    accept     = pc_valid && pc_ready;

    unique case (state_q)
      StIdle: begin
        if (accept) begin
          if (pc_in[1:0] == 2'b00) begin
            addr_d  = pc_in;
            state_d = StReq;
          end else begin
            push       = 1'b1;
            push_entry = make_entry(pc_in, 32'h0, 1'b1);
          end
        end
      end
      StReq: begin
        imem_req = 1'b1;
        if (imem_gnt)   state_d = flush ? StDrop : StWait;
        else if (flush) state_d = StIdle;
      end
      StWait: begin
        if (imem_rvalid) begin
          state_d = StIdle;
          if (!flush) begin
            push       = 1'b1;
            push_entry = make_entry(addr_q, imem_rdata, 1'b0);
          end
        end else if (flush) begin
          state_d = StDrop;
        end
      end
      StDrop: begin
        // The granted response must still be absorbed before issuing again.
        if (imem_rvalid) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  fetch_fifo #(
    .Depth  (DEPTH),
    .EntryT (entry_t)
  ) u_fifo (
    .clk_i   (clk),
    .rst_i   (rst),
    .clear_i (flush),
    .push_i  (push),
    .data_i  (push_entry),
    .pop_i   (if_valid && if_ready),
    .head_o  (head),
    .count_o (count)
  );

  assign imem_addr = addr_q;
  assign if_valid  = (count != '0);
  assign if_pc     = if_valid ? head.pc    : 32'h0;
  assign if_instr  = if_valid ? head.instr : 32'h0;
  assign if_adel   = if_valid && head.adel;

endmodule

// File: tb/tb_instr_fetch_unit.sv
module tb_instr_fetch_unit;

  localparam int DEPTH = 4;

  logic        clk = 1'b0;
  logic        rst, pc_valid, flush, imem_gnt, imem_rvalid, if_ready;
  logic [31:0] pc_in, imem_rdata;
  logic        pc_ready, imem_req, if_valid, if_adel;
  logic [31:0] imem_addr, if_pc, if_instr;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  instr_fetch_unit #(.DEPTH(DEPTH)) dut (
    .clk         (clk),
    .rst         (rst),
    .pc_valid    (pc_valid),
    .pc_in       (pc_in),
    .pc_ready    (pc_ready),
    .flush       (flush),
    .imem_req    (imem_req),
    .imem_addr   (imem_addr),
    .imem_gnt    (imem_gnt),
    .imem_rvalid (imem_rvalid),
    .imem_rdata  (imem_rdata),
    .if_valid    (if_valid),
    .if_ready    (if_ready),
    .if_pc       (if_pc),
    .if_instr    (if_instr),
    .if_adel     (if_adel)
  );

  task automatic chk1(input string nm, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %b expected %b at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic chk32(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- transaction-level reference model ----------------
  typedef struct {
    logic [31:0] pc;
    logic [31:0] instr;
    logic        adel;
  } ent_t;

  ent_t        mq[$];
  ent_t        m_ent;
  bit          m_pend = 0;     // a fetch is in progress (not yet answered/withdrawn)
  bit          m_granted = 0;  // memory has taken the request
  bit          m_alive = 0;    // response is still wanted
  bit          m_acc, m_push;
  logic [31:0] m_pc = '0;

  always @(posedge clk) begin
    m_push = 0;
    if (rst) begin
      mq.delete();
      m_pend = 0; m_granted = 0; m_alive = 0;
    end else begin
      m_acc = pc_valid && !m_pend && (mq.size() < DEPTH) && !flush;
      if (m_pend && !m_granted) begin
        if (imem_gnt) begin m_granted = 1; m_alive = !flush; end
        else if (flush) m_pend = 0;
      end else if (m_pend) begin
        if (imem_rvalid) begin m_pend = 0; m_push = m_alive && !flush; end
        else if (flush) m_alive = 0;
      end
      if (flush) mq.delete();
      else begin
        if (if_ready && mq.size() != 0) mq.delete(0);
        if (m_push) begin
          m_ent.pc = m_pc; m_ent.instr = imem_rdata; m_ent.adel = 1'b0;
          mq.push_back(m_ent);
        end
      end
      if (m_acc) begin
        if (pc_in[1:0] == 2'b00) begin
          m_pend = 1; m_granted = 0; m_alive = 1; m_pc = pc_in;
        end else begin
          m_ent.pc = pc_in; m_ent.instr = 32'h0; m_ent.adel = 1'b1;
          mq.push_back(m_ent);
        end
      end
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    chk1("pc_ready", pc_ready, !m_pend && (mq.size() < DEPTH) && !flush && !rst);
    chk1("imem_req", imem_req, m_pend && !m_granted);
    if (m_pend && !m_granted) chk32("imem_addr", imem_addr, m_pc);
    chk1("if_valid", if_valid, mq.size() != 0);
    if (mq.size() != 0) begin
      chk32("if_pc", if_pc, mq[0].pc);
      chk32("if_instr", if_instr, mq[0].instr);
      chk1("if_adel", if_adel, mq[0].adel);
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic fetch_one(input logic [31:0] pc, input logic [31:0] data);
    pc_valid = 1'b1; pc_in = pc; tick();
    pc_valid = 1'b0; imem_gnt = 1'b1; tick();
    imem_gnt = 1'b0; tick();
    imem_rvalid = 1'b1; imem_rdata = data; tick();
    imem_rvalid = 1'b0;
  endtask

  initial begin
    rst = 1'b1; pc_valid = 0; pc_in = '0; flush = 0; imem_gnt = 0;
    imem_rvalid = 0; imem_rdata = '0; if_ready = 0;
    tick();
    @(negedge clk);
    chk1("rst pc_ready", pc_ready, 1'b0);
    chk1("rst imem_req", imem_req, 1'b0);
    chk32("rst imem_addr", imem_addr, 32'h0);
    chk1("rst if_valid", if_valid, 1'b0);
    chk32("rst if_pc", if_pc, 32'h0);
    chk32("rst if_instr", if_instr, 32'h0);
    chk1("rst if_adel", if_adel, 1'b0);
    tick(); rst = 1'b0;
    @(negedge clk);
    chk1("post-rst pc_ready", pc_ready, 1'b1);

    // Single fetch
    tick();
    fetch_one(32'h0040_0000, 32'h3C01_0040);
    @(negedge clk);
    chk1("single if_valid", if_valid, 1'b1);
    chk32("single if_pc", if_pc, 32'h0040_0000);
    chk32("single if_instr", if_instr, 32'h3C01_0040);
    chk1("single if_adel", if_adel, 1'b0);
    tick(); if_ready = 1'b1; tick(); if_ready = 1'b0;
    @(negedge clk);
    chk1("single popped", if_valid, 1'b0);

    // Full queue
    tick();
    for (int i = 0; i < DEPTH; i++) fetch_one(32'h0040_0000 + 32'(4 * i), 32'h1000_0000 + 32'(i));
    @(negedge clk);
    chk1("full pc_ready", pc_ready, 1'b0);
    tick(); if_ready = 1'b1;
    @(negedge clk);
    chk32("full head0", if_pc, 32'h0040_0000);
    tick(); if_ready = 1'b0;
    @(negedge clk);
    chk1("after pop pc_ready", pc_ready, 1'b1);
    chk32("full head1", if_pc, 32'h0040_0004);
    tick(); if_ready = 1'b1;
    tick(); tick(); tick(); if_ready = 1'b0;
    @(negedge clk);
    chk1("full drained", if_valid, 1'b0);

    // Misaligned PC
    tick(); pc_valid = 1'b1; pc_in = 32'h0040_0002;
    tick(); pc_valid = 1'b0;
    @(negedge clk);
    chk1("adel imem_req", imem_req, 1'b0);
    chk1("adel if_valid", if_valid, 1'b1);
    chk1("adel if_adel", if_adel, 1'b1);
    chk32("adel if_instr", if_instr, 32'h0);
    chk32("adel if_pc", if_pc, 32'h0040_0002);
    tick(); if_ready = 1'b1; tick(); if_ready = 1'b0;

    // Flush in WAIT, with an address-error entry already queued
    tick(); pc_valid = 1'b1; pc_in = 32'h0040_0006;
    tick(); pc_in = 32'h0040_0010;
    tick(); pc_valid = 1'b0; imem_gnt = 1'b1;
    tick(); imem_gnt = 1'b0; flush = 1'b1;
    @(negedge clk);
    chk1("flush pc_ready", pc_ready, 1'b0);
    tick(); flush = 1'b0;
    @(negedge clk);
    chk1("flush cleared queue", if_valid, 1'b0);
    tick(); imem_rvalid = 1'b1; imem_rdata = 32'hDEAD_BEEF;
    tick(); imem_rvalid = 1'b0;
    @(negedge clk);
    chk1("wait-flush pc_ready", pc_ready, 1'b1);
    chk1("wait-flush no entry", if_valid, 1'b0);

    // Flush in REQ without grant withdraws the request
    tick(); pc_valid = 1'b1; pc_in = 32'h0040_0030;
    tick(); pc_valid = 1'b0; flush = 1'b1;
    tick(); flush = 1'b0;
    @(negedge clk);
    chk1("withdraw imem_req", imem_req, 1'b0);
    chk1("withdraw pc_ready", pc_ready, 1'b1);

    // Flush coincident with grant: late response dropped
    tick(); pc_valid = 1'b1; pc_in = 32'h0040_0020;
    tick(); pc_valid = 1'b0; imem_gnt = 1'b1; flush = 1'b1;
    tick(); imem_gnt = 1'b0; flush = 1'b0;
    @(negedge clk);
    chk1("drop imem_req", imem_req, 1'b0);
    chk1("drop pc_ready", pc_ready, 1'b0);
    tick(); imem_rvalid = 1'b1; imem_rdata = 32'hBADB_AD00;
    tick(); imem_rvalid = 1'b0;
    fetch_one(32'h0040_0100, 32'h8C22_0000);
    @(negedge clk);
    chk32("after drop if_pc", if_pc, 32'h0040_0100);
    chk32("after drop if_instr", if_instr, 32'h8C22_0000);
    tick(); if_ready = 1'b1; tick(); if_ready = 1'b0;

    // Reset in WAIT with two queued entries
    fetch_one(32'h0040_0200, 32'h1111_1111);
    fetch_one(32'h0040_0204, 32'h2222_2222);
    pc_valid = 1'b1; pc_in = 32'h0040_0208;
    tick(); pc_valid = 1'b0; imem_gnt = 1'b1;
    tick(); imem_gnt = 1'b0; rst = 1'b1;
    @(negedge clk);
    chk1("rst-wait pc_ready", pc_ready, 1'b0);
    chk1("rst-wait queued", if_valid, 1'b1);
    tick(); rst = 1'b0; imem_rvalid = 1'b1; imem_rdata = 32'h3333_3333;
    @(negedge clk);
    chk1("rst-wait if_valid", if_valid, 1'b0);
    chk1("rst-wait imem_req", imem_req, 1'b0);
    chk32("rst-wait imem_addr", imem_addr, 32'h0);
    chk32("rst-wait if_pc", if_pc, 32'h0);
    chk32("rst-wait if_instr", if_instr, 32'h0);
    chk1("rst-wait if_adel", if_adel, 1'b0);
    chk1("rst-wait pc_ready", pc_ready, 1'b1);
    tick(); imem_rvalid = 1'b0;
    @(negedge clk);
    chk1("stray rvalid ignored", if_valid, 1'b0);
    tick(); tick();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
